// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Holds the FSM state encoding, the requester index type and the RV32I
// funct codes used by requesters to select ADD/SUB.

package alu_arb_pkg;

    // Controller states: IDLE accepts a request, EXEC drives the ALU,
    // RESP returns the captured result for one cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Requester index; also used as grant and owner encoding.
    typedef logic req_idx_t;

    localparam req_idx_t REQ0 = 1'b0;
    localparam req_idx_t REQ1 = 1'b1;

    // RV32I op selectors for the add/subtract pair.
    localparam logic [2:0] FUNCT3_ADD_SUB = 3'd0;
    localparam logic [6:0] FUNCT7_BASE    = 7'd0;
    localparam logic [6:0] FUNCT7_ALT     = 7'd32;

    // Latency counter width; covers ALU_LATENCY up to 15.
    localparam int CNT_W = 4;

    // The opposite requester, used for round-robin tie breaking.
    function automatic req_idx_t other_req(input req_idx_t r);
        return ~r;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way combinational arbiter for the shared ALU.
// A single valid requester always wins. On a tie the requester that did not
// win last time is chosen, unless ALU_ARB_FIXED_PRIORITY_EN is defined, in
// which case requester 0 always wins and the last-grant input disappears.

module arb_rr2
    import alu_arb_pkg::*;
(
    input  logic     valid0_i,
    input  logic     valid1_i,
`ifndef ALU_ARB_FIXED_PRIORITY_EN
    input  req_idx_t last_grant_i,
`endif
    output logic     any_o,
    output req_idx_t grant_o
);

    assign any_o = valid0_i | valid1_i;

    // Grant selection: tie resolution depends on the build option.
    always_comb begin
        grant_o = REQ0;
        if (valid0_i && valid1_i) begin
`ifdef ALU_ARB_FIXED_PRIORITY_EN
            grant_o = REQ0;
`else
            grant_o = other_req(last_grant_i);
`endif
        end else if (valid1_i) begin
            grant_o = REQ1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one RV32I ALU between two valid/ready requesters.
// One operation is in flight at a time: the winner's operands are latched
// onto the ALU inputs, held for ALU_LATENCY cycles, and the ALU result is
// returned as a one-cycle strobe to the requester that issued it.
// Build option: ALU_ARB_FIXED_PRIORITY_EN selects fixed priority (requester 0
// wins ties) instead of round-robin; the default build is round-robin.
//
// state | meaning
// IDLE  | ready offered to the granted requester; handshake latches the op
// EXEC  | ALU enabled with stable inputs; counts ALU_LATENCY cycles
// RESP  | one-cycle result strobe to the owner; no ready offered

module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ALU_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [2:0]            req0_funct3,
    input  logic [6:0]            req0_funct7,
    input  logic [DATA_WIDTH-1:0] req0_rs1,
    input  logic [DATA_WIDTH-1:0] req0_rs2,
    output logic                  resp0_valid,
    output logic [DATA_WIDTH-1:0] resp0_data,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [2:0]            req1_funct3,
    input  logic [6:0]            req1_funct7,
    input  logic [DATA_WIDTH-1:0] req1_rs1,
    input  logic [DATA_WIDTH-1:0] req1_rs2,
    output logic                  resp1_valid,
    output logic [DATA_WIDTH-1:0] resp1_data,

    output logic                  alu_enable,
    output logic [2:0]            alu_funct3,
    output logic [6:0]            alu_funct7,
    output logic [DATA_WIDTH-1:0] alu_register_data_1,
    output logic [DATA_WIDTH-1:0] alu_register_data_2,
    input  logic [DATA_WIDTH-1:0] alu_register_data_out,

    output logic                  busy
);

    // The counter runs 0..ALU_LATENCY-1 while in EXEC; the last value marks
    // the edge on which the ALU result is valid and gets captured.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e                state_q, state_d;
    req_idx_t              owner_q, owner_d;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
    req_idx_t              last_grant_q, last_grant_d;
`endif
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [6:0]            funct7_q, funct7_d;
    logic [DATA_WIDTH-1:0] rs1_q, rs1_d;
    logic [DATA_WIDTH-1:0] rs2_q, rs2_d;
    logic [DATA_WIDTH-1:0] resp0_data_q, resp0_data_d;
    logic [DATA_WIDTH-1:0] resp1_data_q, resp1_data_d;

    logic                  any_valid;
    req_idx_t              grant;
    logic                  take;

    arb_rr2 u_arb (
        .valid0_i     (req0_valid),
        .valid1_i     (req1_valid),
`ifndef ALU_ARB_FIXED_PRIORITY_EN
        .last_grant_i (last_grant_q),
`endif
        .any_o        (any_valid),
        .grant_o      (grant)
    );

    // Ready is only ever offered in IDLE, and only to the granted requester,
    // so a handshake is simply "take" qualified by the grant.
    assign take        = (state_q == IDLE) && any_valid;
    assign req0_ready  = take && (grant == REQ0);
    assign req1_ready  = take && (grant == REQ1);

    assign alu_enable  = (state_q == EXEC);
    assign resp0_valid = (state_q == RESP) && (owner_q == REQ0);
    assign resp1_valid = (state_q == RESP) && (owner_q == REQ1);
    assign busy        = (state_q != IDLE);

    assign alu_funct3          = funct3_q;
    assign alu_funct7          = funct7_q;
    assign alu_register_data_1 = rs1_q;
    assign alu_register_data_2 = rs2_q;
    assign resp0_data          = resp0_data_q;
    assign resp1_data          = resp1_data_q;

    // Next-state and datapath-load decisions for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
        last_grant_d = last_grant_q;
`endif
        cnt_d        = cnt_q;
        funct3_d     = funct3_q;
        funct7_d     = funct7_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        resp0_data_d = resp0_data_q;
        resp1_data_d = resp1_data_q;

        case (state_q)
            IDLE: begin
                if (take) begin
                    funct3_d     = (grant == REQ1) ? req1_funct3 : req0_funct3;
                    funct7_d     = (grant == REQ1) ? req1_funct7 : req0_funct7;
                    rs1_d        = (grant == REQ1) ? req1_rs1    : req0_rs1;
                    rs2_d        = (grant == REQ1) ? req1_rs2    : req0_rs2;
                    owner_d      = grant;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
                    last_grant_d = grant;
`endif
                    cnt_d        = '0;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    // Only the owner's result register moves; the other
                    // requester keeps seeing its previous result.
                    if (owner_q == REQ1) begin
                        resp1_data_d = alu_register_data_out;
                    end else begin
                        resp0_data_d = alu_register_data_out;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any op in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            owner_q      <= REQ0;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
            last_grant_q <= REQ1;
`endif
            cnt_q        <= '0;
            funct3_q     <= '0;
            funct7_q     <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            resp0_data_q <= '0;
            resp1_data_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
            last_grant_q <= last_grant_d;
`endif
            cnt_q        <= cnt_d;
            funct3_q     <= funct3_d;
            funct7_q     <= funct7_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            resp0_data_q <= resp0_data_d;
            resp1_data_q <= resp1_data_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: instance "a" runs with ALU_LATENCY=1 behind a
// combinational ALU model, instance "b" with ALU_LATENCY=4 behind a model
// whose result appears three registers after its inputs.

module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int DW    = 32;
    localparam int LAT_A = 1;
    localparam int LAT_B = 4;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- instance a signals ----------------
    logic a_rst_n;
    logic a_v0, a_rdy0, a_rv0, a_v1, a_rdy1, a_rv1;
    logic [2:0] a_f30, a_f31, a_f3;
    logic [6:0] a_f70, a_f71, a_f7;
    logic [DW-1:0] a_rs10, a_rs20, a_rs11, a_rs21, a_rd0, a_rd1;
    logic a_en, a_busy;
    logic [DW-1:0] a_op1, a_op2, a_out;

    // ---------------- instance b signals ----------------
    logic b_rst_n;
    logic b_v0, b_rdy0, b_rv0, b_v1, b_rdy1, b_rv1;
    logic [2:0] b_f30, b_f31, b_f3;
    logic [6:0] b_f70, b_f71, b_f7;
    logic [DW-1:0] b_rs10, b_rs20, b_rs11, b_rs21, b_rd0, b_rd1;
    logic b_en, b_busy;
    logic [DW-1:0] b_op1, b_op2, b_out;
    logic [DW-1:0] b_pipe0 = '0, b_pipe1 = '0, b_pipe2 = '0;

    logic [DW-1:0] a_q0[$];
    logic [DW-1:0] a_q1[$];
    logic [DW-1:0] b_q0[$];

    function automatic logic [31:0] alu_f(input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        case (f3)
            3'd0:    r = f7[5] ? x - y : x + y;
            3'd1:    r = x << y[4:0];
            3'd2:    r = {31'd0, $signed(x) < $signed(y)};
            3'd3:    r = {31'd0, x < y};
            3'd4:    r = x ^ y;
            3'd5:    r = f7[5] ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
            3'd6:    r = x | y;
            default: r = x & y;
        endcase
        return r;
    endfunction

    assign a_out = alu_f(a_f3, a_f7, a_op1, a_op2);

    always @(posedge clock) begin
        b_pipe0 <= alu_f(b_f3, b_f7, b_op1, b_op2);
        b_pipe1 <= b_pipe0;
        b_pipe2 <= b_pipe1;
    end
    assign b_out = b_pipe2;

    alu_arbiter #(.DATA_WIDTH(DW), .ALU_LATENCY(LAT_A)) dut_a (
        .clock(clock), .reset_n(a_rst_n),
        .req0_valid(a_v0), .req0_ready(a_rdy0), .req0_funct3(a_f30), .req0_funct7(a_f70),
        .req0_rs1(a_rs10), .req0_rs2(a_rs20), .resp0_valid(a_rv0), .resp0_data(a_rd0),
        .req1_valid(a_v1), .req1_ready(a_rdy1), .req1_funct3(a_f31), .req1_funct7(a_f71),
        .req1_rs1(a_rs11), .req1_rs2(a_rs21), .resp1_valid(a_rv1), .resp1_data(a_rd1),
        .alu_enable(a_en), .alu_funct3(a_f3), .alu_funct7(a_f7),
        .alu_register_data_1(a_op1), .alu_register_data_2(a_op2),
        .alu_register_data_out(a_out), .busy(a_busy)
    );

    alu_arbiter #(.DATA_WIDTH(DW), .ALU_LATENCY(LAT_B)) dut_b (
        .clock(clock), .reset_n(b_rst_n),
        .req0_valid(b_v0), .req0_ready(b_rdy0), .req0_funct3(b_f30), .req0_funct7(b_f70),
        .req0_rs1(b_rs10), .req0_rs2(b_rs20), .resp0_valid(b_rv0), .resp0_data(b_rd0),
        .req1_valid(b_v1), .req1_ready(b_rdy1), .req1_funct3(b_f31), .req1_funct7(b_f71),
        .req1_rs1(b_rs11), .req1_rs2(b_rs21), .resp1_valid(b_rv1), .resp1_data(b_rd1),
        .alu_enable(b_en), .alu_funct3(b_f3), .alu_funct7(b_f7),
        .alu_register_data_1(b_op1), .alu_register_data_2(b_op2),
        .alu_register_data_out(b_out), .busy(b_busy)
    );

    task automatic test_reset();
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_v0 = 0; a_v1 = 0; b_v0 = 0; b_v1 = 0;
        a_f30 = 0; a_f70 = 0; a_rs10 = 0; a_rs20 = 0;
        a_f31 = 0; a_f71 = 0; a_rs11 = 0; a_rs21 = 0;
        b_f30 = 0; b_f70 = 0; b_rs10 = 0; b_rs20 = 0;
        b_f31 = 0; b_f71 = 0; b_rs11 = 0; b_rs21 = 0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({a_rdy0, a_rdy1, a_rv0, a_rv1, a_en, a_busy} !== 6'b0) begin
            n_bad++; $display("FAIL reset_a_ctrl: got %b want 000000", {a_rdy0, a_rdy1, a_rv0, a_rv1, a_en, a_busy});
        end
        n_cmp++;
        if ({a_rd0, a_rd1, a_op1, a_op2, a_f3, a_f7} !== '0) begin
            n_bad++; $display("FAIL reset_a_data: got %h %h %h %h want all zero", a_rd0, a_rd1, a_op1, a_op2);
        end
        n_cmp++;
        if ({b_rdy0, b_rdy1, b_rv0, b_rv1, b_en, b_busy} !== 6'b0) begin
            n_bad++; $display("FAIL reset_b_ctrl: got %b want 000000", {b_rdy0, b_rdy1, b_rv0, b_rv1, b_en, b_busy});
        end
        n_cmp++;
        if ({b_rd0, b_rd1, b_op1, b_op2, b_f3, b_f7} !== '0) begin
            n_bad++; $display("FAIL reset_b_data: got %h %h %h %h want all zero", b_rd0, b_rd1, b_op1, b_op2);
        end
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_idle_busy: got %b%b want 00", a_busy, b_busy);
        end
    endtask

    task automatic test_add();
        int hs_cyc, got_cyc, pulses, r1_pulses;
        logic [DW-1:0] exp_v;
        a_q0.delete();
        got_cyc = -1; pulses = 0; r1_pulses = 0;
        @(negedge clock);
        a_v0 = 1; a_f30 = FUNCT3_ADD_SUB; a_f70 = FUNCT7_BASE; a_rs10 = 32'd1; a_rs20 = 32'd2;
        #1;
        n_cmp++;
        if (a_rdy0 !== 1'b1 || a_rdy1 !== 1'b0) begin
            n_bad++; $display("FAIL add_ready: got %b%b want 10", a_rdy0, a_rdy1);
        end
        a_q0.push_back(32'h0000_0003);
        hs_cyc = cyc;
        @(negedge clock);
        a_v0 = 0;
        for (int i = 0; i < 10; i++) begin
            if (a_rv1 === 1'b1) r1_pulses++;
            if (a_rv0 === 1'b1) begin
                pulses++;
                if (got_cyc < 0) got_cyc = cyc;
                if (a_q0.size() > 0) begin
                    exp_v = a_q0.pop_front();
                    n_cmp++;
                    if (a_rd0 !== exp_v) begin
                        n_bad++; $display("FAIL add_data: got %h want %h", a_rd0, exp_v);
                    end
                end
            end
            @(negedge clock);
        end
        n_cmp++;
        if (pulses !== 1) begin n_bad++; $display("FAIL add_pulses: got %0d want 1", pulses); end
        n_cmp++;
        if (got_cyc - hs_cyc !== LAT_A + 1) begin
            n_bad++; $display("FAIL add_latency: got %0d want %0d", got_cyc - hs_cyc, LAT_A + 1);
        end
        n_cmp++;
        if (r1_pulses !== 0) begin n_bad++; $display("FAIL add_resp1_quiet: got %0d want 0", r1_pulses); end
    endtask

    task automatic test_sub();
        int pulses, r0_pulses, en_cyc, bad_f7;
        logic [DW-1:0] exp_v;
        a_q1.delete();
        pulses = 0; r0_pulses = 0; en_cyc = 0; bad_f7 = 0;
        @(negedge clock);
        a_v1 = 1; a_f31 = FUNCT3_ADD_SUB; a_f71 = FUNCT7_ALT; a_rs11 = 32'd5; a_rs21 = 32'd7;
        #1;
        n_cmp++;
        if (a_rdy1 !== 1'b1 || a_rdy0 !== 1'b0) begin
            n_bad++; $display("FAIL sub_ready: got %b%b want 01", a_rdy0, a_rdy1);
        end
        a_q1.push_back(32'hFFFF_FFFE);
        @(negedge clock);
        a_v1 = 0;
        for (int i = 0; i < 10; i++) begin
            if (a_en === 1'b1) begin
                en_cyc++;
                if (a_f7 !== 7'h20 || a_f3 !== 3'd0 || a_op1 !== 32'd5 || a_op2 !== 32'd7) bad_f7++;
            end
            if (a_rv0 === 1'b1) r0_pulses++;
            if (a_rv1 === 1'b1) begin
                pulses++;
                if (a_q1.size() > 0) begin
                    exp_v = a_q1.pop_front();
                    n_cmp++;
                    if (a_rd1 !== exp_v) begin
                        n_bad++; $display("FAIL sub_data: got %h want %h", a_rd1, exp_v);
                    end
                end
            end
            @(negedge clock);
        end
        n_cmp++;
        if (pulses !== 1 || r0_pulses !== 0) begin
            n_bad++; $display("FAIL sub_pulses: got resp1=%0d resp0=%0d want 1 0", pulses, r0_pulses);
        end
        n_cmp++;
        if (en_cyc !== LAT_A || bad_f7 !== 0) begin
            n_bad++; $display("FAIL sub_exec_inputs: got en=%0d bad=%0d want %0d 0", en_cyc, bad_f7, LAT_A);
        end
        n_cmp++;
        if (a_rd0 !== 32'h0000_0003) begin
            n_bad++; $display("FAIL sub_resp0_hold: got %h want 00000003", a_rd0);
        end
    endtask

    task automatic test_tie();
        int nresp, both_rdy, both_resp;
        logic exp_owner;
        logic [DW-1:0] exp_v;
        a_q0.delete(); a_q1.delete();
        nresp = 0; both_rdy = 0; both_resp = 0; exp_owner = 1'b0;
        @(negedge clock);
        a_rst_n = 1'b0;
        @(negedge clock);
        a_rst_n = 1'b1;
        for (int i = 0; i < 60 && nresp < 6; i++) begin
            @(negedge clock);
            if (i == 0) begin
                a_v0 = 1; a_f30 = FUNCT3_ADD_SUB; a_f70 = FUNCT7_BASE; a_rs10 = 32'd1;  a_rs20 = 32'd2;
                a_v1 = 1; a_f31 = FUNCT3_ADD_SUB; a_f71 = FUNCT7_BASE; a_rs11 = 32'd10; a_rs21 = 32'd20;
            end
            if (a_rv0 === 1'b1 && a_rv1 === 1'b1) both_resp++;
            if (a_rv0 === 1'b1 || a_rv1 === 1'b1) begin
                nresp++;
                n_cmp++;
                if (a_rv1 !== exp_owner) begin
                    n_bad++; $display("FAIL tie_order: resp %0d got owner %b want %b", nresp, a_rv1, exp_owner);
                end
`ifndef ALU_ARB_FIXED_PRIORITY_EN
                exp_owner = ~exp_owner;
`endif
                if (a_rv1 === 1'b1) begin
                    if (a_q1.size() == 0) begin
                        n_cmp++; n_bad++; $display("FAIL tie_data1: got %h want none queued", a_rd1);
                    end else begin
                        exp_v = a_q1.pop_front();
                        n_cmp++;
                        if (a_rd1 !== exp_v) begin n_bad++; $display("FAIL tie_data1: got %h want %h", a_rd1, exp_v); end
                    end
                end else begin
                    if (a_q0.size() == 0) begin
                        n_cmp++; n_bad++; $display("FAIL tie_data0: got %h want none queued", a_rd0);
                    end else begin
                        exp_v = a_q0.pop_front();
                        n_cmp++;
                        if (a_rd0 !== exp_v) begin n_bad++; $display("FAIL tie_data0: got %h want %h", a_rd0, exp_v); end
                    end
                end
            end
            if (nresp >= 6) begin a_v0 = 0; a_v1 = 0; end
            #1;
            if (a_rdy0 === 1'b1 && a_rdy1 === 1'b1) both_rdy++;
            if (a_rdy0 === 1'b1 && a_v0 === 1'b1) a_q0.push_back(32'h0000_0003);
            if (a_rdy1 === 1'b1 && a_v1 === 1'b1) a_q1.push_back(32'h0000_001E);
        end
        n_cmp++;
        if (nresp !== 6) begin n_bad++; $display("FAIL tie_count: got %0d want 6", nresp); end
        n_cmp++;
        if (both_rdy !== 0 || both_resp !== 0) begin
            n_bad++; $display("FAIL tie_exclusive: got rdy=%0d resp=%0d want 0 0", both_rdy, both_resp);
        end
        repeat (3) @(negedge clock);
        n_cmp++;
        if (a_q0.size() !== 0 || a_q1.size() !== 0 || a_busy !== 1'b0) begin
            n_bad++; $display("FAIL tie_drain: got q0=%0d q1=%0d busy=%b want 0 0 0", a_q0.size(), a_q1.size(), a_busy);
        end
    endtask

    task automatic test_latency();
        int hs_cyc, got_cyc, en_cyc, bad_busy, pulses;
        logic [DW-1:0] exp_v;
        b_q0.delete();
        got_cyc = -1; en_cyc = 0; bad_busy = 0; pulses = 0;
        @(negedge clock);
        b_v0 = 1; b_f30 = FUNCT3_ADD_SUB; b_f70 = FUNCT7_BASE; b_rs10 = 32'd9; b_rs20 = 32'd1;
        #1;
        n_cmp++;
        if (b_rdy0 !== 1'b1 || b_busy !== 1'b0) begin
            n_bad++; $display("FAIL lat_ready: got rdy=%b busy=%b want 1 0", b_rdy0, b_busy);
        end
        b_q0.push_back(32'h0000_000A);
        hs_cyc = cyc;
        @(negedge clock);
        b_v0 = 0;
        for (int i = 0; i < 15; i++) begin
            if (b_en === 1'b1) en_cyc++;
            if (b_busy !== (b_en | b_rv0)) bad_busy++;
            if (b_rv0 === 1'b1) begin
                pulses++;
                if (got_cyc < 0) got_cyc = cyc;
                if (b_q0.size() > 0) begin
                    exp_v = b_q0.pop_front();
                    n_cmp++;
                    if (b_rd0 !== exp_v) begin n_bad++; $display("FAIL lat_data: got %h want %h", b_rd0, exp_v); end
                end
            end
            @(negedge clock);
        end
        n_cmp++;
        if (en_cyc !== LAT_B) begin n_bad++; $display("FAIL lat_enable: got %0d want %0d", en_cyc, LAT_B); end
        n_cmp++;
        if (got_cyc - hs_cyc !== LAT_B + 1 || pulses !== 1) begin
            n_bad++; $display("FAIL lat_timing: got %0d pulses=%0d want %0d 1", got_cyc - hs_cyc, pulses, LAT_B + 1);
        end
        n_cmp++;
        if (bad_busy !== 0) begin n_bad++; $display("FAIL lat_busy: got %0d bad cycles want 0", bad_busy); end
    endtask

    task automatic test_reset_exec();
        int en_cyc, stray, hs_cyc, got_cyc;
        logic hit;
        logic [DW-1:0] exp_v;
        b_q0.delete();
        en_cyc = 0; stray = 0; got_cyc = -1; hit = 1'b0;
        @(negedge clock);
        b_v0 = 1; b_f30 = FUNCT3_ADD_SUB; b_f70 = FUNCT7_BASE; b_rs10 = 32'd3; b_rs20 = 32'd4;
        @(negedge clock);
        b_v0 = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            if (b_en === 1'b1) en_cyc++;
            if (en_cyc == 2) begin
                hit = 1'b1;
                b_rst_n = 1'b0;
                #1;
                n_cmp++;
                if ({b_rdy0, b_rdy1, b_rv0, b_rv1, b_en, b_busy} !== 6'b0 ||
                    {b_rd0, b_rd1, b_op1, b_op2, b_f3, b_f7} !== '0) begin
                    n_bad++; $display("FAIL rst_exec_outputs: got ctrl=%b op1=%h rd0=%h want all zero",
                                      {b_rdy0, b_rdy1, b_rv0, b_rv1, b_en, b_busy}, b_op1, b_rd0);
                end
            end else begin
                @(negedge clock);
            end
        end
        n_cmp++;
        if (!hit) begin n_bad++; $display("FAIL rst_exec_reach: got enable cycles %0d want 2", en_cyc); end
        for (int i = 0; i < 8; i++) begin
            if (i == 2) b_rst_n = 1'b1;
            @(negedge clock);
            if (b_rv0 === 1'b1 || b_rv1 === 1'b1) stray++;
        end
        n_cmp++;
        if (stray !== 0) begin n_bad++; $display("FAIL rst_exec_noresp: got %0d strobes want 0", stray); end
        b_v0 = 1; b_rs10 = 32'd1; b_rs20 = 32'd1;
        #1;
        b_q0.push_back(32'h0000_0002);
        hs_cyc = cyc;
        @(negedge clock);
        b_v0 = 0;
        for (int i = 0; i < 12; i++) begin
            if (b_rv0 === 1'b1 && got_cyc < 0) begin
                got_cyc = cyc;
                if (b_q0.size() > 0) begin
                    exp_v = b_q0.pop_front();
                    n_cmp++;
                    if (b_rd0 !== exp_v) begin n_bad++; $display("FAIL rst_exec_next: got %h want %h", b_rd0, exp_v); end
                end
            end
            @(negedge clock);
        end
        n_cmp++;
        if (got_cyc - hs_cyc !== LAT_B + 1) begin
            n_bad++; $display("FAIL rst_exec_next_lat: got %0d want %0d", got_cyc - hs_cyc, LAT_B + 1);
        end
    endtask

    task automatic test_back_to_back();
        int sent, nresp, last_hs, bad_gap;
        logic hs_prev;
        logic [DW-1:0] exp_v;
        a_q0.delete();
        sent = 0; nresp = 0; last_hs = -1; bad_gap = 0; hs_prev = 1'b0;
        for (int i = 0; i < 100 && nresp < 6; i++) begin
            @(negedge clock);
            if (a_rv0 === 1'b1) begin
                nresp++;
                if (a_q0.size() == 0) begin
                    n_cmp++; n_bad++; $display("FAIL b2b_data: got %h want none queued", a_rd0);
                end else begin
                    exp_v = a_q0.pop_front();
                    n_cmp++;
                    if (a_rd0 !== exp_v) begin n_bad++; $display("FAIL b2b_data: op %0d got %h want %h", nresp, a_rd0, exp_v); end
                end
            end
            if (i == 0 || hs_prev) begin
                if (sent < 6) begin
                    a_v0   = 1;
                    a_f30  = 3'($urandom_range(0, 7));
                    a_f70  = ((a_f30 == 3'd0 || a_f30 == 3'd5) && ($urandom_range(0, 1) == 1)) ? FUNCT7_ALT : FUNCT7_BASE;
                    a_rs10 = $urandom;
                    a_rs20 = $urandom;
                end else begin
                    a_v0 = 0;
                end
                hs_prev = 1'b0;
            end
            #1;
            if (a_v0 === 1'b1 && a_rdy0 === 1'b1) begin
                a_q0.push_back(alu_f(a_f30, a_f70, a_rs10, a_rs20));
                if (last_hs >= 0 && (cyc - last_hs) != LAT_A + 2) bad_gap++;
                last_hs = cyc;
                sent++;
                hs_prev = 1'b1;
            end
        end
        n_cmp++;
        if (nresp !== 6 || sent !== 6) begin
            n_bad++; $display("FAIL b2b_count: got sent=%0d resp=%0d want 6 6", sent, nresp);
        end
        n_cmp++;
        if (bad_gap !== 0) begin n_bad++; $display("FAIL b2b_spacing: got %0d bad gaps want 0", bad_gap); end
        n_cmp++;
        if (a_q0.size() !== 0) begin n_bad++; $display("FAIL b2b_drain: got %0d left want 0", a_q0.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_tie();
        test_latency();
        test_reset_exec();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
